// File: rtl/serial_add_seq_pkg.sv
// Shared calculator constants: sequencer state encoding and default operand width.
package serial_add_seq_pkg;

  localparam int CALC_WIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_add_seq_fa.sv
// Full-adder bit cell; an active-low Rst forces both outputs low.
module FA (
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic Rst,
  output logic S,
  output logic Cry
);

  always_comb begin
    S   = 1'b0;
    Cry = 1'b0;
    if (Rst) begin
      S   = A ^ B ^ C;
      Cry = (A & B) | (A & C) | (B & C);
    end
  end

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: streams operand bits LSB first through one FA cell.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CW-1:0]    count_reg;
  logic             carry_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             carry_out_reg;
  logic             overflow_reg;
  logic             cell_s;
  logic             cell_cry;

  FA bit_cell (
    .A   (a_sr_reg[0]),
    .B   (b_sr_reg[0]),
    .C   (carry_reg),
    .Rst (1'b1),
    .S   (cell_s),
    .Cry (cell_cry)
  );

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg     <= S_IDLE;
      a_sr_reg      <= '0;
      b_sr_reg      <= '0;
      result_reg    <= '0;
      count_reg     <= '0;
      carry_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      carry_out_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_RUN: begin
          result_reg <= {cell_s, result_reg[WIDTH-1:1]};
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          carry_reg  <= cell_cry;
          if (count_reg == LAST) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            overflow_reg  <= carry_reg ^ cell_cry;
            carry_out_reg <= cell_cry;
            state_reg     <= S_DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; subtraction is A + ~B + 1.
          if (Start) begin
            a_sr_reg  <= OpA;
            b_sr_reg  <= Sub ? ~OpB : OpB;
            carry_reg <= Sub;
            count_reg <= '0;
            state_reg <= S_RUN;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign Busy     = busy_reg;
  assign Done     = done_reg;
  assign Result   = result_reg;
  assign CarryOut = carry_out_reg;
  assign Overflow = overflow_reg;

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial add/subtract sequencer for the calculator datapath. It sits directly upstream of the full-adder cell. It latches two WIDTH-bit operands, feeds the cell one bit pair plus the registered carry per clock (LSB first), and collects the cell's sum and carry back into a result shift register. It reports the result, carry-out and signed overflow with a one-cycle Done pulse.

## Interface
- WIDTH, default 8: operand/result width in bits, minimum 2.
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-low reset.
- Start  input  1  request; sampled only when accepting (IDLE or DONE state).
- Sub  input  1  0 = A+B, 1 = A−B; sampled with Start.
- OpA  input  WIDTH  operand A; sampled with Start.
- OpB  input  WIDTH  operand B; sampled with Start.
- Busy  output  1  high while in RUN.
- Done  output  1  single-cycle pulse, result valid.
- Result  output  WIDTH  sum/difference; held until the next accepted Start.
- CarryOut  output  1  final carry (subtract: 1 = no borrow).
- Overflow  output  1  two's-complement overflow.

## Operation
- The state machine has three states: IDLE, RUN, DONE. In reset (Rst=0 at a clock edge):
  - state goes to IDLE.
  - Busy, Done, Result, CarryOut and Overflow all go to 0.
  - bit counter and carry register go to 0.
- IDLE: if Start=1, the block accepts the request:
  - a_sr ← OpA.
  - b_sr ← OpB, or ~OpB when Sub=1.
  - carry ← Sub.
  - count ← 0.
  - state → RUN.
  - Otherwise it stays in IDLE.
- RUN, each cycle:
  - Drive the cell with A=a_sr[0], B=b_sr[0], C=carry.
  - Result shifts right, and the cell sum S enters at the MSB.
  - a_sr and b_sr shift right.
  - carry ← Cry.
  - count increments.
- Overflow capture in RUN: on the cycle count=WIDTH−1, Overflow ← carry XOR Cry (carry into the MSB XOR carry out of the MSB). At the same edge, CarryOut ← Cry and state → DONE.
- DONE: Done=1 for exactly this cycle; state → IDLE unless Start=1, in which case the new request is accepted exactly as in IDLE (back-to-back operation).
- Start in RUN is ignored and is not queued.
- Sub, OpA and OpB may change freely after acceptance without effect.
- Result, CarryOut and Overflow are not cleared on DONE. They are overwritten only by the next operation; Result changes during RUN as bits shift in.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH) bits and never wraps past WIDTH−1 in RUN.

## Timing
- Start accepted at edge 0 → Busy high from edge 0 through edge WIDTH−1 → Done high during the cycle after edge WIDTH. Latency is WIDTH+1 cycles from Start to Done.
- Throughput: one operation per WIDTH+1 cycles when Start is held high continuously.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-RUN: at the next edge with Rst=0, the operation is abandoned.
  - All outputs go to 0 and the state goes to IDLE.
  - No Done is produced for the abandoned operation.
  - A Start in the same cycle as Rst=0 is ignored.

## Structure
- Shared calculator package holds:
  - the state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - the default operand width constant CALC_WIDTH=8.
- One sub-module: the existing full-adder cell FA, instantiated once as the bit cell, with its Rst pin tied inactive. All sequencing, shift registers and the carry flip-flop live in serial_add_seq.

## Test plan
- Addition: WIDTH=8, Sub=0, OpA=0x3C, OpB=0x0F, Start pulse → Done exactly 9 cycles later, Result=0x4B, CarryOut=0, Overflow=0; Busy high for 8 cycles.
- Unsigned wrap: OpA=0xFF, OpB=0x01, Sub=0 → Result=0x00, CarryOut=1, Overflow=0.
- Signed overflow: OpA=0x7F, OpB=0x01, Sub=0 → Result=0x80, Overflow=1. Then, subtracting: OpA=0x80, OpB=0x01, Sub=1 → Result=0x7F, Overflow=1, CarryOut=1.
- Borrow on subtract: OpA=0x05, OpB=0x07, Sub=1 → Result=0xFE, CarryOut=0, Overflow=0.
- Start while busy and back-to-back:
  - Start again at RUN cycle 3 with different operands → ignored; the first result is unchanged.
  - Start held high through DONE → second operation accepted, and its Done arrives 9 cycles after the first Done.
- Reset mid-operation: Rst=0 for one cycle at RUN cycle 4 → next cycle Busy=0, Result=0, no Done pulse. A fresh Start then completes normally.
